mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle MIPS control unit. A Moore FSM steps each instruction through fetch, decode,
//  execute, memory and writeback. It drives datapath muxes and enables, and the 3-bit ALU control.
//  Sits beside the multicycle datapath; consumes op/funct from IR and zero from the ALU.
//  Adds a memory-ready wait handshake, illegal-instruction flag and retired-instruction counter.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter (>=2)
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      asynchronous, active-high reset
//  op          in   6      IR[31:26]
//  funct       in   6      IR[5:0]
//  zero        in   1      ALU zero flag
//  mem_ready   in   1      memory completes access this cycle
//  irwrite     out  1      IR load enable
//  memwrite    out  1      memory write strobe
//  regwrite    out  1      register-file write enable
//  pcen        out  1      PC load = pcwrite | (branch & zero)
//  iord        out  1      0: address=PC, 1: address=ALUOut
//  memtoreg    out  1      writeback data 1: MDR, 0: ALUOut
//  regdst      out  1      dest reg 1: rd, 0: rt
//  alusrca     out  1      0: PC, 1: A
//  alusrcb     out  2      00 B, 01 const 4, 10 signimm, 11 signimm<<2
//  pcsrc       out  2      00 ALUResult, 01 ALUOut, 10 jump target
//  alucontrol  out  3      010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal     out  1      1-cycle pulse on unsupported op/funct
//  state_o     out  4      current state encoding (debug)
//  retired     out  CNT_W  count of completed instructions
// BEHAVIOUR
//  - reset: state FETCH (0), retired=0; while reset=1, all enables (irwrite, memwrite, regwrite,
//    pcen) forced 0 and illegal=0. Reset mid-instruction aborts it; no partial writes after.
//  - Unlisted outputs are 0 in each state. Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3,
//    MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12.
//  - FETCH: alusrcb=01, irwrite=pcwrite=mem_ready; -> DECODE when mem_ready, else hold.
//  - DECODE: alusrcb=11. op 100011/101011->MEMADR, 000000->RTYPEEX, 000100->BEQEX,
//    001000->ADDIEX, 000010->JEX; any other op -> FETCH with illegal=1.
//  - MEMADR: alusrca=1, alusrcb=10; lw->MEMRD, sw->MEMWR.
//  - MEMRD: iord=1; hold until mem_ready, then ->MEMWB.
//  - MEMWB: memtoreg=1, regwrite=1 ->FETCH.
//  - MEMWR: iord=1, memwrite=1 held until mem_ready, then ->FETCH.
//  - RTYPEEX: alusrca=1, aluop=10; funct in {add,sub,and,or,slt} ->RTYPEWB,
//    else illegal=1, ->FETCH.
//  - RTYPEWB: regdst=1, regwrite=1 ->FETCH.
//  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1 ->FETCH. ADDIEX: alusrca=1, alusrcb=10
//    ->ADDIWB. ADDIWB: regwrite=1 ->FETCH. JEX: pcsrc=10, pcwrite=1 ->FETCH.
//  - alucontrol: aluop 00->010, 01->110, 10-> funct decode
//    (100000 010, 100010 110, 100100 000, 100101 001, 101010 111, other 010).
//  - retired: +1 on each exit to FETCH from MEMWB, MEMWR (mem_ready=1), RTYPEWB, BEQEX,
//    ADDIWB, JEX, BNEEX; not on illegal exit; wraps 2^CNT_W-1 -> 0.
//  - Latency (mem_ready=1): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
// CONFIGURATION
//  MC_BNE_EN defined: op 000101 in DECODE -> BNEEX (as BEQEX, but pcen=branch & ~zero).
//  Undefined: op 000101 is illegal; state 12 unreachable.
// TESTING
//  - reset high, mem_ready=1 -> enables all 0; release -> FETCH with irwrite=pcen=1.
//  - lw op=100011, mem_ready low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; regwrite only in 4.
//  - R add funct=100000 -> RTYPEEX alucontrol=010, RTYPEWB regdst=1 regwrite=1; retired+1.
//  - beq zero=1 -> pcen=1 in BEQEX; zero=0 -> pcen=0; both retire.
//  - op=111111 -> illegal pulse in DECODE, back to FETCH, retired unchanged; MC_BNE_EN off, op=000101 same.
//  - CNT_W=2, 4 addi -> retired 1,2,3,0; reset asserted in MEMWR -> memwrite drops async, retired=0.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM with a memory-ready wait handshake,
// an illegal-instruction pulse and a retired-instruction counter.
// Optional feature macro: MC_BNE_EN adds bne support through the BNEEX state.
module mc_controller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic             pcen,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic       irwrite_c, memwrite_c, regwrite_c, pcwrite_c;
    logic       branch_c, branch_ne_c, illegal_c, retire_c;
    logic [1:0] aluop_c;
    logic       funct_ok_c;

    // Supported R-type function codes
    always_comb begin
        funct_ok_c = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_ok_c = 1'b1;
            default:                               funct_ok_c = 1'b0;
        endcase
    end

    // State and retired-counter registers; reset aborts any in-flight instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d     = state_q;
        irwrite_c   = 1'b0;
        memwrite_c  = 1'b0;
        regwrite_c  = 1'b0;
        pcwrite_c   = 1'b0;
        branch_c    = 1'b0;
        branch_ne_c = 1'b0;
        illegal_c   = 1'b0;
        retire_c    = 1'b0;
        iord        = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop_c     = 2'b00;

        case (state_q)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite_c = mem_ready;
                pcwrite_c = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop_c = 2'b10;
                if (funct_ok_c) begin
                    state_d = S_RTYPEWB;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                aluop_c  = 2'b01;
                pcsrc    = 2'b01;
                branch_c = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                pcwrite_c = 1'b1;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef MC_BNE_EN
            S_BNEEX: begin
                alusrca     = 1'b1;
                aluop_c     = 2'b01;
                pcsrc       = 2'b01;
                branch_ne_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // ALU control from aluop and funct
    always_comb begin
        alucontrol = 3'b010;
        case (aluop_c)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    FN_ADD:  alucontrol = 3'b010;
                    FN_SUB:  alucontrol = 3'b110;
                    FN_AND:  alucontrol = 3'b000;
                    FN_OR:   alucontrol = 3'b001;
                    FN_SLT:  alucontrol = 3'b111;
                    default: alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // Retired counter advances on every completed instruction, wrapping naturally
    always_comb begin
        retired_d = retire_c ? (retired_q + CNT_W'(1)) : retired_q;
    end

    // Write enables and illegal flag are suppressed while reset is held
    always_comb begin
        irwrite  = irwrite_c & ~reset;
        memwrite = memwrite_c & ~reset;
        regwrite = regwrite_c & ~reset;
        pcen     = (pcwrite_c | (branch_c & zero) | (branch_ne_c & ~zero)) & ~reset;
        illegal  = illegal_c & ~reset;
        state_o  = state_q;
        retired  = retired_q;
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller; a second instance with CNT_W=2 shares
// the stimulus so counter wrap can be observed alongside the full-width count.
module tb_mc_controller;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero, mem_ready;
    logic        irwrite, memwrite, regwrite, pcen, iord, memtoreg, regdst, alusrca, illegal;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [3:0]  state_o;
    logic [31:0] retired;

    logic        irwrite2, memwrite2, regwrite2, pcen2, iord2, memtoreg2, regdst2, alusrca2, illegal2;
    logic [1:0]  alusrcb2, pcsrc2;
    logic [2:0]  alucontrol2;
    logic [3:0]  state2;
    logic [1:0]  retired2;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_ret = 0;

    always #5 clk = ~clk;

    mc_controller u_dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite), .pcen(pcen), .iord(iord),
        .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal(illegal), .state_o(state_o), .retired(retired)
    );

    mc_controller #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .irwrite(irwrite2), .memwrite(memwrite2), .regwrite(regwrite2), .pcen(pcen2), .iord(iord2),
        .memtoreg(memtoreg2), .regdst(regdst2), .alusrca(alusrca2), .alusrcb(alusrcb2), .pcsrc(pcsrc2),
        .alucontrol(alucontrol2), .illegal(illegal2), .state_o(state2), .retired(retired2)
    );

    // Count a comparison and report a mismatch
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Drive one cycle of inputs at the falling edge, then check the current state
    task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic z, input logic mr,
                       input logic [3:0] es, input string tag);
        @(negedge clk);
        op = o; funct = f; zero = z; mem_ready = mr;
        #1;
        chk(tag, 32'(state_o), 32'(es));
    endtask

    task automatic run_r(input logic [5:0] f, input logic [2:0] alu, input bit ok);
        cyc(OP_R, f, 1'b0, 1'b1, 4'd1, "r_decode");
        cyc(OP_R, f, 1'b0, 1'b1, 4'd6, "r_ex");
        chk("r_alucontrol", 32'(alucontrol), 32'(alu));
        chk("r_illegal", 32'(illegal), ok ? 32'd0 : 32'd1);
        if (ok) begin
            cyc(OP_R, f, 1'b0, 1'b1, 4'd7, "r_wb");
            chk("r_wb_regdst", 32'(regdst), 32'd1);
            chk("r_wb_regwrite", 32'(regwrite), 32'd1);
            exp_ret++;
        end
        cyc(OP_R, f, 1'b0, 1'b1, 4'd0, "r_done");
        chk("r_retired", retired, 32'(exp_ret));
    endtask

    task automatic run_branch(input logic [5:0] o, input logic [3:0] ex_state, input logic z,
                              input logic exp_pcen);
        cyc(o, 6'd0, z, 1'b1, 4'd1, "br_decode");
        chk("br_decode_pcen", 32'(pcen), 32'd0);
        cyc(o, 6'd0, z, 1'b1, ex_state, "br_ex");
        chk("br_pcen", 32'(pcen), 32'(exp_pcen));
        chk("br_pcsrc", 32'(pcsrc), 32'd1);
        chk("br_alucontrol", 32'(alucontrol), 32'd6);
        exp_ret++;
        cyc(o, 6'd0, z, 1'b1, 4'd0, "br_done");
        chk("br_retired", retired, 32'(exp_ret));
    endtask

    task automatic run_illegal(input logic [5:0] o);
        cyc(o, 6'd0, 1'b0, 1'b1, 4'd1, "ill_decode");
        chk("ill_pulse", 32'(illegal), 32'd1);
        chk("ill_regwrite", 32'(regwrite), 32'd0);
        cyc(o, 6'd0, 1'b0, 1'b1, 4'd0, "ill_fetch");
        chk("ill_cleared", 32'(illegal), 32'd0);
        chk("ill_retired", retired, 32'(exp_ret));
    endtask

    task automatic run_addi(input logic [1:0] exp_wrap);
        cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd1, "addi_decode");
        cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd9, "addi_ex");
        chk("addi_alusrcb", 32'(alusrcb), 32'd2);
        cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd10, "addi_wb");
        chk("addi_regwrite", 32'(regwrite), 32'd1);
        chk("addi_regdst", 32'(regdst), 32'd0);
        exp_ret++;
        cyc(OP_ADDI, 6'd0, 1'b0, 1'b1, 4'd0, "addi_done");
        chk("addi_retired", retired, 32'(exp_ret));
        chk("addi_retired_wrap", 32'(retired2), 32'(exp_wrap));
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; op = OP_BAD; funct = 6'd0; zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_irwrite", 32'(irwrite), 32'd0);
        chk("rst_pcen", 32'(pcen), 32'd0);
        chk("rst_memwrite", 32'(memwrite), 32'd0);
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_retired", retired, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("fetch_irwrite", 32'(irwrite), 32'd1);
        chk("fetch_pcen", 32'(pcen), 32'd1);
        chk("fetch_alusrcb", 32'(alusrcb), 32'd1);

        // lw with two wait cycles in MEMRD
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 4'd1, "lw_decode");
        chk("lw_decode_alusrcb", 32'(alusrcb), 32'd3);
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 4'd2, "lw_memadr");
        chk("lw_memadr_alusrca", 32'(alusrca), 32'd1);
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 4'd3, "lw_memrd0");
        chk("lw_memrd_iord", 32'(iord), 32'd1);
        chk("lw_memrd_regwrite", 32'(regwrite), 32'd0);
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 4'd3, "lw_memrd1");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 4'd3, "lw_memrd2");
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 4'd4, "lw_memwb");
        chk("lw_memwb_regwrite", 32'(regwrite), 32'd1);
        chk("lw_memwb_memtoreg", 32'(memtoreg), 32'd1);
        exp_ret++;
        cyc(OP_LW, 6'd0, 1'b0, 1'b1, 4'd0, "lw_done");
        chk("lw_retired", retired, 32'(exp_ret));

        // R-type decode variants and an unsupported funct
        run_r(6'b100000, 3'b010, 1'b1);
        run_r(6'b100010, 3'b110, 1'b1);
        run_r(6'b101010, 3'b111, 1'b1);
        run_r(6'b100101, 3'b001, 1'b1);
        run_r(6'b000000, 3'b010, 1'b0);

        // beq taken and not taken
        run_branch(OP_BEQ, 4'd8, 1'b1, 1'b1);
        run_branch(OP_BEQ, 4'd8, 1'b0, 1'b0);

        run_illegal(OP_BAD);
`ifdef MC_BNE_EN
        run_branch(OP_BNE, 4'd12, 1'b0, 1'b1);
        run_branch(OP_BNE, 4'd12, 1'b1, 1'b0);
`else
        run_illegal(OP_BNE);
`endif

        // sw completing without wait
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, 4'd1, "sw_decode");
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, 4'd2, "sw_memadr");
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, 4'd5, "sw_memwr");
        chk("sw_memwrite", 32'(memwrite), 32'd1);
        chk("sw_iord", 32'(iord), 32'd1);
        exp_ret++;
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, 4'd0, "sw_done");
        chk("sw_retired", retired, 32'(exp_ret));

        // Fresh reset, then four addi to watch the 2-bit counter wrap
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst2_retired", retired, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_ret = 0;
        run_addi(2'd1);
        run_addi(2'd2);
        run_addi(2'd3);
        run_addi(2'd0);

        // Jump
        cyc(OP_J, 6'd0, 1'b0, 1'b1, 4'd1, "j_decode");
        cyc(OP_J, 6'd0, 1'b0, 1'b1, 4'd11, "j_ex");
        chk("j_pcen", 32'(pcen), 32'd1);
        chk("j_pcsrc", 32'(pcsrc), 32'd2);
        exp_ret++;
        cyc(OP_J, 6'd0, 1'b0, 1'b1, 4'd0, "j_done");
        chk("j_retired", retired, 32'(exp_ret));

        // sw stalled in MEMWR, then aborted by an asynchronous reset
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, 4'd1, "swr_decode");
        cyc(OP_SW, 6'd0, 1'b0, 1'b1, 4'd2, "swr_memadr");
        cyc(OP_SW, 6'd0, 1'b0, 1'b0, 4'd5, "swr_memwr0");
        chk("swr_memwrite0", 32'(memwrite), 32'd1);
        cyc(OP_SW, 6'd0, 1'b0, 1'b0, 4'd5, "swr_memwr1");
        chk("swr_memwrite1", 32'(memwrite), 32'd1);
        chk("swr_no_retire", retired, 32'(exp_ret));
        #1;
        reset = 1'b1;
        #1;
        chk("swr_memwrite_async", 32'(memwrite), 32'd0);
        chk("swr_state_async", 32'(state_o), 32'd0);
        chk("swr_retired_async", retired, 32'd0);
        chk("swr_retired2_async", 32'(retired2), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("post_rst_state", 32'(state_o), 32'd0);
        chk("post_rst_memwrite", 32'(memwrite), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
